// File: rtl/div_defs_pkg.sv
// Shared definitions for the divide control stage: op and FSM encodings, default width.
// Latency: n/a (package).
// Backpressure: n/a (package).
package div_defs;

   localparam int DEF_WIDTH = 32;

   // LoongArch divide opcodes as presented by EX
   typedef enum logic [1:0] {
      DIV_W  = 2'b00,
      MOD_W  = 2'b01,
      DIV_WU = 2'b10,
      MOD_WU = 2'b11
   } div_op_e;

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_BUSY  = 2'b01,
      S_DRAIN = 2'b10,
      S_DONE  = 2'b11
   } div_state_e;

   // op[1]=0 selects the signed variants, op[0]=1 selects remainder
   function automatic logic op_is_signed(input div_op_e op);
      return !op[1];
   endfunction

   function automatic logic op_is_mod(input div_op_e op);
      return op[0];
   endfunction

endpackage

// File: rtl/div_sign_fix.sv
// Sign correction: picks quotient or remainder and restores its sign for signed ops.
// Latency: combinational.
// Backpressure: none.
// Ports: quot_i/rem_i unsigned divider results, op_i opcode, neg_q_i/neg_r_i sign
//        flags captured at request time, result_o final architectural result.
module div_sign_fix
   import div_defs::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic [WIDTH-1:0] quot_i,
   input  logic [WIDTH-1:0] rem_i,
   input  div_op_e          op_i,
   input  logic             neg_q_i,
   input  logic             neg_r_i,
   output logic [WIDTH-1:0] result_o
);

   logic is_signed;

   assign is_signed = op_is_signed(op_i);

   // Divide-by-zero and INT_MIN/-1 need no special casing here: the divider
   // returns q=0/r=|dividend| for zero, and -(0x80000000) wraps to itself.
   always_comb begin
      result_o = quot_i;
      if (op_is_mod(op_i)) begin
         result_o = (is_signed && neg_r_i) ? -rem_i : rem_i;
      end else begin
         result_o = (is_signed && neg_q_i) ? -quot_i : quot_i;
      end
   end

endmodule

// File: rtl/div_ctrl.sv
// Divide control: sign handling and sequencing around the unsigned iterative divider.
// Latency: result one cycle after div_ready (fast path: one cycle after acceptance).
// Backpressure: stall held while a request is pending and no result is being returned.
// Ports: req_* from EX, flush kills the in-flight op, stall holds EX, res_valid/res_data
//        return the result, div_* drive and observe the unsigned divider.
// Optional: DIV_FASTPATH_EN resolves |divisor|<=1 and |dividend|<|divisor| without the divider.
module div_ctrl
   import div_defs::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             req_valid,
   input  logic [1:0]       req_op,
   input  logic [WIDTH-1:0] req_src1,
   input  logic [WIDTH-1:0] req_src2,
   input  logic             flush,
   output logic             stall,
   output logic             res_valid,
   output logic [WIDTH-1:0] res_data,
   output logic             div_en,
   output logic [WIDTH-1:0] div_dividend,
   output logic [WIDTH-1:0] div_divisor,
   output logic             div_flush,
   input  logic [WIDTH-1:0] div_quotient,
   input  logic [WIDTH-1:0] div_remainder,
   input  logic             div_ready
);

   div_state_e       state_q;
   div_op_e          op_q;
   logic             neg_q_q;
   logic             neg_r_q;
   logic             div_en_q;
   logic [WIDTH-1:0] dividend_q;
   logic [WIDTH-1:0] divisor_q;
   logic [WIDTH-1:0] res_data_q;

   div_op_e          req_op_e;
   logic             req_signed;
   logic [WIDTH-1:0] mag1;
   logic [WIDTH-1:0] mag2;
   logic             req_neg_q;
   logic             req_neg_r;
   logic             accept;
   logic             fast_hit;
   logic [WIDTH-1:0] fast_quot;
   logic [WIDTH-1:0] fast_rem;

   logic             fix_idle;
   logic [WIDTH-1:0] fix_quot;
   logic [WIDTH-1:0] fix_rem;
   div_op_e          fix_op;
   logic             fix_neg_q;
   logic             fix_neg_r;
   logic [WIDTH-1:0] fix_result;

   assign req_op_e   = div_op_e'(req_op);
   assign req_signed = op_is_signed(req_op_e);
   assign mag1       = (req_signed && req_src1[WIDTH-1]) ? -req_src1 : req_src1;
   assign mag2       = (req_signed && req_src2[WIDTH-1]) ? -req_src2 : req_src2;
   assign req_neg_q  = req_signed & (req_src1[WIDTH-1] ^ req_src2[WIDTH-1]);
   assign req_neg_r  = req_signed & req_src1[WIDTH-1];
   assign accept     = (state_q == S_IDLE) & req_valid & ~flush;

`ifdef DIV_FASTPATH_EN
   // Trivial cases answered from magnitudes alone, in the same form the divider would return
   assign fast_hit  = (mag2 == '0) | (mag2 == WIDTH'(1)) | (mag1 < mag2);
   assign fast_quot = (mag2 == WIDTH'(1)) ? mag1 : '0;
   assign fast_rem  = (mag2 == WIDTH'(1)) ? '0 : mag1;
`else
   assign fast_hit  = 1'b0;
   assign fast_quot = '0;
   assign fast_rem  = '0;
`endif

   // One sign-fix instance serves both paths: IDLE only ever uses the fast-path
   // inputs, every other state uses the divider outputs and the latched flags.
   assign fix_idle  = (state_q == S_IDLE);
   assign fix_quot  = fix_idle ? fast_quot : div_quotient;
   assign fix_rem   = fix_idle ? fast_rem  : div_remainder;
   assign fix_op    = fix_idle ? req_op_e  : op_q;
   assign fix_neg_q = fix_idle ? req_neg_q : neg_q_q;
   assign fix_neg_r = fix_idle ? req_neg_r : neg_r_q;

   div_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
      .quot_i   (fix_quot),
      .rem_i    (fix_rem),
      .op_i     (fix_op),
      .neg_q_i  (fix_neg_q),
      .neg_r_i  (fix_neg_r),
      .result_o (fix_result)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= S_IDLE;
         op_q       <= DIV_W;
         neg_q_q    <= 1'b0;
         neg_r_q    <= 1'b0;
         div_en_q   <= 1'b0;
         dividend_q <= '0;
         divisor_q  <= '0;
         res_data_q <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  op_q    <= req_op_e;
                  neg_q_q <= req_neg_q;
                  neg_r_q <= req_neg_r;
                  if (fast_hit) begin
                     res_data_q <= fix_result;
                     state_q    <= S_DONE;
                  end else begin
                     dividend_q <= mag1;
                     divisor_q  <= mag2;
                     div_en_q   <= 1'b1;
                     state_q    <= S_BUSY;
                  end
               end
            end
            S_BUSY: begin
               if (div_ready) begin
                  div_en_q <= 1'b0;
                  if (flush) begin
                     state_q <= S_IDLE;
                  end else begin
                     res_data_q <= fix_result;
                     state_q    <= S_DONE;
                  end
               end else if (flush) begin
                  state_q <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               // Divider cannot be aborted mid-iteration; wait it out and discard
               if (div_ready) begin
                  div_en_q <= 1'b0;
                  state_q  <= S_IDLE;
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign stall        = req_valid & ~flush & (state_q != S_DONE);
   assign res_valid    = (state_q == S_DONE) & ~flush;
   assign res_data     = res_data_q;
   assign div_en       = div_en_q;
   assign div_dividend = dividend_q;
   assign div_divisor  = divisor_q;
   // Releasing the divider from DONE only makes sense while it reports ready
   assign div_flush    = div_ready & ((state_q == S_BUSY) | (state_q == S_DRAIN));

endmodule

// File: doc/div_ctrl.md
# div_ctrl

Control and sign-handling stage wrapped around the unsigned iterative divider in the EX stage. Accepts LoongArch div.w/mod.w/div.wu/mod.wu requests from EX and converts signed operands to magnitudes. Drives and releases the unsigned divider, applies sign correction, and returns one 32-bit result with a single-cycle valid. Stalls the pipeline while a divide is in flight and cleanly drains the divider on pipeline flush.

## Interface
- WIDTH, 32, operand/result width
- clk  in  1  system clock, all state on rising edge
- rstn  in  1  asynchronous active-low reset
- req_valid  in  1  EX holds a divide op; held stable until res_valid or flush
- req_op  in  2  00 div.w, 01 mod.w, 10 div.wu, 11 mod.wu
- req_src1  in  WIDTH  dividend
- req_src2  in  WIDTH  divisor
- flush  in  1  pipeline flush/exception; kills the in-flight op
- stall  out  1  hold EX (combinational)
- res_valid  out  1  result valid, one-cycle pulse
- res_data  out  WIDTH  result; holds the last value between pulses
- div_en  out  1  to divider en
- div_dividend  out  WIDTH  registered dividend magnitude to divider
- div_divisor  out  WIDTH  registered divisor magnitude to divider
- div_flush  out  1  to divider flush_exception; returns it from DONE to IDLE
- div_quotient  in  WIDTH  divider quotient (unsigned)
- div_remainder  in  WIDTH  divider remainder (unsigned)
- div_ready  in  1  divider in DONE; quotient/remainder valid

## Operation
- States: IDLE, BUSY, DRAIN, DONE. Reset: IDLE; all outputs 0, res_data 0.
- IDLE: if req_valid & !flush, latch op, neg_q, neg_r, and operand magnitudes (signed ops negate negative operands; unsigned ops pass operands through). Go to BUSY.
- BUSY: div_en=1 with div_dividend/div_divisor stable.
  - On div_ready: compute the result, load res_data, pulse div_flush, go to DONE.
  - On flush (without div_ready): go to DRAIN.
  - If flush and div_ready coincide: pulse div_flush, discard the result, go to IDLE.
- DRAIN: div_en=1. On div_ready: pulse div_flush, discard, go to IDLE. No new request is accepted in DRAIN.
- DONE: res_valid=1 for exactly one cycle, then go to IDLE. If flush arrives in DONE, res_valid is suppressed.
- Sign rules (signed ops only):
  - neg_q = src1[31]^src2[31]; neg_r = src1[31].
  - Quotient is negated if neg_q; remainder is negated if neg_r.
- Divide by zero (divider returns q=0, r=|dividend|): div.* → 0; mod.* → src1 unchanged.
- Overflow 0x80000000 / 0xFFFFFFFF (div.w) → 0x80000000; mod.w → 0.
- stall = req_valid & !flush & (state≠DONE).
- div_flush is asserted only in a cycle where div_ready=1.

## Timing
- Request accepted at cycle T (IDLE) → div_en high from T+1.
- Divider ready at cycle R → res_data loaded and div_flush pulsed at R → res_valid at R+1. Divider is back in IDLE at R+1.
- stall is high from T through R inclusive and low at R+1.
- Back-to-back divides: next acceptance at R+2 earliest.
- Reset mid-operation: immediate return to IDLE with outputs 0. The divider shares rstn.

## Configuration
- DIV_FASTPATH_EN defined: in IDLE, the following resolve without engaging the divider. The block goes directly to DONE (res_valid at T+1, div_en never asserted):
  - |divisor|==0
  - |divisor|==1
  - |dividend|<|divisor| (unsigned magnitude compare)
- DIV_FASTPATH_EN undefined: every request goes through the divider.

## Structure
- Shared package/header div_defs holds:
  - op encodings (DIV_W, MOD_W, DIV_WU, MOD_WU)
  - state encodings
  - WIDTH default
- Sub-module div_sign_fix: combinational. Takes quotient, remainder, op, neg_q, neg_r and produces the final result. It is reused by the fast path.

## Test plan
- div.w src1=0xFFFFFFF9 (-7), src2=2 → res_data 0xFFFFFFFD (-3); mod.w same operands → 0xFFFFFFFF (-1).
- div.wu 0xFFFFFFF9 / 2 → 0x7FFFFFFC; mod.wu → 1. stall is high until the cycle before res_valid.
- mod.w 0x12345678 / 0 → 0x12345678; div.w by 0 → 0. Repeat with DIV_FASTPATH_EN: res_valid at T+1 and div_en never high.
- div.w 0x80000000 / 0xFFFFFFFF → 0x80000000, with exactly one res_valid pulse.
- Flush 3 cycles after acceptance → no res_valid; div_flush pulses on div_ready. A new request presented during DRAIN is accepted only after the drain, and its result is correct.
- rstn low while in BUSY → all outputs 0 next edge. A subsequent div.wu 100/7 → 14.
